// File: rtl/seg7_arb_if.sv
// seg7_arb_if: request/value bundle from the display sources and the arbitrated display feed
interface seg7_arb_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*16-1:0] req_value;
    logic [NUM_REQ*4-1:0]  req_dots;
    logic                  lock;
    logic [NUM_REQ-1:0]    grant;
    logic [15:0]           disp_value;
    logic [3:0]            disp_dots;
    logic                  disp_valid;

    modport master (
        output req, req_value, req_dots, lock,
        input  grant, disp_value, disp_dots, disp_valid
    );

    modport slave (
        input  req, req_value, req_dots, lock,
        output grant, disp_value, disp_dots, disp_valid
    );
endinterface

// File: rtl/seg7_display_arbiter.sv
// seg7_display_arbiter: round-robin owner of the 4-digit display with minimum hold and a blank gap on handover
module seg7_display_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int HOLD_CYCLES = 50000000
) (
    input logic       clk_sys,
    input logic       rst_n,
    seg7_arb_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(HOLD_CYCLES);

    typedef enum logic [1:0] {IDLE, OWN, SWITCH} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] rr_ptr, win;
    logic [HW-1:0] hold_cnt;
    logic          any_req, own_req, others, hold_done, take, load, valid_nx;

    // rr_ptr always names the current owner while in OWN, and the previous owner in SWITCH
    assign any_req   = |bus.req;
    assign own_req   = bus.req[rr_ptr];
    assign others    = |(bus.req & ~bus.grant);
    assign hold_done = hold_cnt == HW'(HOLD_CYCLES - 1);
    assign load      = state == OWN && own_req;
    assign valid_nx  = load || (state_nx != IDLE && bus.disp_valid);

    // round-robin search starting just after the last winner; the last winner itself is checked last
    always_comb begin
        win = rr_ptr;
        for (int k = NUM_REQ; k >= 1; k--)
            if (bus.req[(int'(rr_ptr) + k) % NUM_REQ]) win = IW'((int'(rr_ptr) + k) % NUM_REQ);
    end

    // next state: grant from IDLE/SWITCH, release on drop, preempt only after hold expiry when unlocked
    always_comb begin
        state_nx = state;
        take     = 1'b0;
        case (state)
            IDLE, SWITCH: begin
                state_nx = any_req ? OWN : IDLE;
                take     = any_req;
            end
            OWN: state_nx = !own_req ? (others ? SWITCH : IDLE)
                          : (hold_done && !bus.lock && others) ? SWITCH : OWN;
            default: state_nx = IDLE;
        endcase
    end

    // state, arbitration pointer, hold counter and registered display feed
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_ptr         <= IW'(NUM_REQ - 1);
            hold_cnt       <= '0;
            bus.grant      <= '0;
            bus.disp_value <= 16'h0000;
            bus.disp_dots  <= 4'h0;
            bus.disp_valid <= 1'b0;
        end else begin
            state          <= state_nx;
            rr_ptr         <= take ? win : rr_ptr;
            bus.grant      <= take ? NUM_REQ'(1) << win : (state_nx == OWN ? bus.grant : '0);
            hold_cnt       <= take ? '0 : (state == OWN && !hold_done) ? hold_cnt + 1'b1 : hold_cnt;
            bus.disp_valid <= valid_nx;
            if (load) begin
                bus.disp_value <= bus.req_value[16*rr_ptr +: 16];
                bus.disp_dots  <= bus.req_dots[4*rr_ptr +: 4];
            end
        end
    end
endmodule

// File: tb/tb_seg7_display_arbiter.sv
// tb_seg7_display_arbiter: table-driven and scoreboarded checks of display arbitration
module tb_seg7_display_arbiter;
    localparam int NUM_REQ = 3;
    localparam int HOLD    = 8;

    typedef struct {
        bit         rst;
        logic [2:0] req;
        bit         lock;
        int         rep;
        logic [2:0] g;
        logic [15:0] v;
        logic [3:0] d;
        logic       vl;
    } vec_t;

    typedef struct {
        logic [2:0]  g;
        logic [15:0] v;
        logic [3:0]  d;
        logic        vl;
    } exp_t;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[$];
    exp_t sb[$];

    seg7_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

    seg7_display_arbiter #(.NUM_REQ(NUM_REQ), .HOLD_CYCLES(HOLD)) dut (
        .clk_sys(clk_sys),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic vec_t mk(bit rst, logic [2:0] req, bit lock, int rep,
                                logic [2:0] g, logic [15:0] v, logic [3:0] d, logic vl);
        vec_t r;
        r.rst = rst; r.req = req; r.lock = lock; r.rep = rep;
        r.g = g; r.v = v; r.d = d; r.vl = vl;
        return r;
    endfunction

    function automatic exp_t mke(logic [2:0] g, logic [15:0] v, logic [3:0] d, logic vl);
        exp_t e;
        e.g = g; e.v = v; e.d = d; e.vl = vl;
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare(string tag, exp_t e);
        check({tag, " grant"}, 32'(bus.grant), 32'(e.g));
        check({tag, " value"}, 32'(bus.disp_value), 32'(e.v));
        check({tag, " dots"}, 32'(bus.disp_dots), 32'(e.d));
        check({tag, " valid"}, 32'(bus.disp_valid), 32'(e.vl));
        check({tag, " onehot"}, 32'($countones(bus.grant) <= 1), 32'd1);
    endtask

    task automatic do_reset(string tag);
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.lock = 1'b0;
        #1;
        compare({tag, " reset"}, mke(3'b000, 16'h0000, 4'h0, 1'b0));
        @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        bus.req       = '0;
        bus.lock      = 1'b0;
        bus.req_value = {16'h0C02, 16'h12AB, 16'hA000};
        bus.req_dots  = 12'h421;

        // single requester, then owner drops with nobody waiting
        tbl.push_back(mk(1, 3'b000, 0, 0, 3'b000, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 3'b010, 0, 1, 3'b010, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 3'b010, 0, 3, 3'b010, 16'h12AB, 4'h2, 1));
        tbl.push_back(mk(0, 3'b000, 0, 2, 3'b000, 16'h12AB, 4'h2, 0));
        // all three requesting: full rotation with one-cycle gaps
        tbl.push_back(mk(1, 3'b000, 0, 0, 3'b000, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 3'b111, 0, 1, 3'b001, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 3'b111, 0, 7, 3'b001, 16'hA000, 4'h1, 1));
        tbl.push_back(mk(0, 3'b111, 0, 1, 3'b000, 16'hA000, 4'h1, 1));
        tbl.push_back(mk(0, 3'b111, 0, 1, 3'b010, 16'hA000, 4'h1, 1));
        tbl.push_back(mk(0, 3'b111, 0, 7, 3'b010, 16'h12AB, 4'h2, 1));
        tbl.push_back(mk(0, 3'b111, 0, 1, 3'b000, 16'h12AB, 4'h2, 1));
        tbl.push_back(mk(0, 3'b111, 0, 1, 3'b100, 16'h12AB, 4'h2, 1));
        tbl.push_back(mk(0, 3'b111, 0, 7, 3'b100, 16'h0C02, 4'h4, 1));
        tbl.push_back(mk(0, 3'b111, 0, 1, 3'b000, 16'h0C02, 4'h4, 1));
        tbl.push_back(mk(0, 3'b111, 0, 1, 3'b001, 16'h0C02, 4'h4, 1));
        tbl.push_back(mk(0, 3'b111, 0, 1, 3'b001, 16'hA000, 4'h1, 1));
        // lock freezes preemption; drop still releases; SWITCH with nobody left goes idle
        tbl.push_back(mk(1, 3'b000, 0, 0, 3'b000, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 3'b011, 0, 1, 3'b001, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 3'b011, 1, 13, 3'b001, 16'hA000, 4'h1, 1));
        tbl.push_back(mk(0, 3'b011, 0, 1, 3'b000, 16'hA000, 4'h1, 1));
        tbl.push_back(mk(0, 3'b011, 0, 1, 3'b010, 16'hA000, 4'h1, 1));
        tbl.push_back(mk(0, 3'b011, 0, 1, 3'b010, 16'h12AB, 4'h2, 1));
        tbl.push_back(mk(0, 3'b001, 1, 1, 3'b000, 16'h12AB, 4'h2, 1));
        tbl.push_back(mk(0, 3'b001, 1, 1, 3'b001, 16'h12AB, 4'h2, 1));
        tbl.push_back(mk(0, 3'b001, 1, 1, 3'b001, 16'hA000, 4'h1, 1));
        tbl.push_back(mk(0, 3'b010, 0, 1, 3'b000, 16'hA000, 4'h1, 1));
        tbl.push_back(mk(0, 3'b000, 0, 1, 3'b000, 16'hA000, 4'h1, 0));

        for (int r = 0; r < tbl.size(); r++) begin
            if (tbl[r].rst) begin
                do_reset($sformatf("row%0d", r));
            end else begin
                for (int c = 0; c < tbl[r].rep; c++) begin
                    bus.req  = tbl[r].req;
                    bus.lock = tbl[r].lock;
                    sb.push_back(mke(tbl[r].g, tbl[r].v, tbl[r].d, tbl[r].vl));
                    @(posedge clk_sys);
                    #1;
                    e = sb.pop_front();
                    compare($sformatf("row%0d.%0d", r, c), e);
                end
            end
        end

        // lone owner keeps the display while its value steps every cycle
        do_reset("lone");
        bus.req = 3'b100;
        bus.req_value[47:32] = 16'h0000;
        @(posedge clk_sys);
        #1;
        compare("lone grant", mke(3'b100, 16'h0000, 4'h0, 1'b0));
        for (int i = 1; i <= 100; i++) begin
            bus.req_value[47:32] = 16'(i);
            sb.push_back(mke(3'b100, 16'(i), 4'h4, 1'b1));
            @(posedge clk_sys);
            #1;
            e = sb.pop_front();
            compare($sformatf("lone%0d", i), e);
        end

        // asynchronous reset mid-ownership, then a fresh grant from the reset pointer
        #2;
        rst_n = 1'b0;
        #1;
        compare("async reset", mke(3'b000, 16'h0000, 4'h0, 1'b0));
        @(posedge clk_sys);
        #1;
        rst_n   = 1'b1;
        bus.req = 3'b110;
        @(posedge clk_sys);
        #1;
        compare("post reset grant", mke(3'b010, 16'h0000, 4'h0, 1'b0));
        @(posedge clk_sys);
        #1;
        compare("post reset show", mke(3'b010, 16'h12AB, 4'h2, 1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
